// File: rtl/cop_irq_ctl.sv
// Coprocessor-bus interrupt controller: a free-running/auto-reload timer, eight
// synchronized edge-triggered external sources, W1C status and a 3-state request FSM.

`ifndef DMEM_SW
`define DMEM_SW 4'b1000
`endif
`ifndef DMEM_LW
`define DMEM_LW 4'b0100
`endif

module cop_irq_ctl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter logic [31:0] VEC_RST   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cop_addr_i,
    input  logic [31:0] cop_data_i,
    input  logic [3:0]  cop_mem_ctl_i,
    output logic [31:0] cop_dout_o,
    input  logic [7:0]  ext_irq_i,
    output logic        irq_o,
    output logic [31:0] irq_addr_o,
    input  logic        iack_i
);

    localparam logic [3:0] C_SW = `DMEM_SW;
    localparam logic [3:0] C_LW = `DMEM_LW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2
    } irq_state_t;

    irq_state_t  r_state;
    irq_state_t  w_state_nxt;

    logic [2:0]  r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [8:0]  r_status;
    logic [8:0]  r_mask;
    logic [31:0] r_vector;
    logic [31:0] r_dout;
    logic        r_irq;
    logic [31:0] r_irq_addr;

    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [7:0]  r_sync3;

    logic [29:0] w_word_addr;
    logic [2:0]  w_idx;
    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_wr_mask;
    logic        w_wr_vector;
    logic [31:0] w_rdata;
    logic        w_hit;
    logic [7:0]  w_ext_rise;
    logic [8:0]  w_status_set;
    logic [8:0]  w_status_clr;
    logic        w_active;

    // Byte offset bits drop out of the word address; they never affect decode.
    assign w_word_addr = 30'(cop_addr_i >> 2);
    assign w_idx       = w_word_addr[2:0];
    assign w_sel       = (w_word_addr[29:3] == BASE_ADDR[31:5]);
    assign w_wr        = w_sel && (cop_mem_ctl_i == C_SW);
    assign w_rd        = w_sel && (cop_mem_ctl_i == C_LW);

    assign w_wr_ctrl   = w_wr && (w_idx == 3'd0);
    assign w_wr_load   = w_wr && (w_idx == 3'd1);
    assign w_wr_count  = w_wr && (w_idx == 3'd2);
    assign w_wr_status = w_wr && (w_idx == 3'd3);
    assign w_wr_mask   = w_wr && (w_idx == 3'd4);
    assign w_wr_vector = w_wr && (w_idx == 3'd5);

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            3'd0:    w_rdata = {29'd0, r_ctrl};
            3'd1:    w_rdata = r_load;
            3'd2:    w_rdata = r_count;
            3'd3:    w_rdata = {23'd0, r_status};
            3'd4:    w_rdata = {23'd0, r_mask};
            3'd5:    w_rdata = r_vector;
            default: w_rdata = '0;
        endcase
    end

    // Load data is driven only for the cycle after a read; the bus is OR-combined.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_rd ? w_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= ext_irq_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_ext_rise = r_sync2 & ~r_sync3;
    assign w_hit      = r_ctrl[0] && (r_count == 32'd0);

    // A software COUNT/CTRL write overrides what the timer would do this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl  <= '0;
            r_load  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= cop_data_i[2:0];
            end else if (w_hit && !r_ctrl[1]) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= cop_data_i;
            end

            if (w_wr_count) begin
                r_count <= cop_data_i;
            end else if (w_hit && r_ctrl[1]) begin
                r_count <= r_load;
            end else if (r_ctrl[0] && !w_hit) begin
                r_count <= r_count - 32'd1;
            end
        end
    end

    assign w_status_set = {w_ext_rise, w_hit};
    assign w_status_clr = w_wr_status ? cop_data_i[8:0] : 9'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
            r_mask   <= '0;
            r_vector <= VEC_RST;
        end else begin
            // Set is OR-ed after the clear so a coincident event is never lost.
            r_status <= (r_status & ~w_status_clr) | w_status_set;
            if (w_wr_mask) begin
                r_mask <= cop_data_i[8:0];
            end
            if (w_wr_vector) begin
                r_vector <= cop_data_i;
            end
        end
    end

    assign w_active = r_ctrl[2] && (|(r_status & r_mask));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_active) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (iack_i) begin
                    w_state_nxt = S_SERV;
                end else if (!w_active) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SERV: begin
                if (!w_active) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_irq      <= 1'b0;
            r_irq_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == S_REQ);
            // Handler address is latched once per request so it cannot move under irq_o.
            if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
                r_irq_addr <= r_vector;
            end
        end
    end

    assign cop_dout_o = r_dout;
    assign irq_o      = r_irq;
    assign irq_addr_o = r_irq_addr;

endmodule
